// File: rtl/control_pkg.sv
// control_pkg
// Shared definitions for the Control Unit sequencer and its helpers.
//   state_t      : sequencer state encoding (IDLE, FETCH, DECODE, START, RUN, TRAP)
//   MAX_FSM      : number of class masks defined here; N_FSM must not exceed it
//   FSM_MASK[i]  : 32-bit one-hot class-code mask claimed by instruction-class FSM i
//   TRAP_*       : trap cause codes reported on trap_cause
//   mask_hit()   : true when a class code falls inside FSM i's mask
package control_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        FETCH  = 3'b001,
        DECODE = 3'b010,
        START  = 3'b011,
        RUN    = 3'b100,
        TRAP   = 3'b111
    } state_t;

    localparam int MAX_FSM = 8;

    // Index 0 is the ALU class and holds code[12]. Code bits that appear in
    // no mask (2, 3, 13-15, 28-31) are illegal class codes.
    localparam logic [31:0] FSM_MASK [MAX_FSM] = '{
        32'h0000_1003,   // 0: ALU
        32'h0000_00F0,   // 1: load/store
        32'h0000_0F00,   // 2: branch/jump
        32'h00FF_0000,   // 3: system
        32'h0100_0000,   // 4: spare
        32'h0200_0000,   // 5: spare
        32'h0400_0000,   // 6: spare
        32'h0800_0000    // 7: spare
    };

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    function automatic logic mask_hit(input logic [31:0] code, input int idx);
        return |(code & FSM_MASK[idx]);
    endfunction

endpackage

// File: rtl/fsm_select.sv
// fsm_select
// Combinational priority encoder from a one-hot class code to the one-hot
// FSM selection. The lowest-index FSM whose mask overlaps the code wins.
// Ports:
//   code  in  32     class code from the opdecoder
//   sel   out N_FSM  one-hot selection (all zero when nothing matches)
//   match out 1      at least one mask matched
module fsm_select
    import control_pkg::*;
#(
    parameter int N_FSM = 4
) (
    input  logic [31:0]      code,
    output logic [N_FSM-1:0] sel,
    output logic             match
);

    // Walk from index 0 upward and stop claiming once a hit is found, so
    // overlapping masks resolve to the highest-priority (lowest) index.
    always_comb begin
        sel   = '0;
        match = 1'b0;
        for (int i = 0; i < N_FSM; i++) begin
            if (!match && mask_hit(code, i)) begin
                sel[i] = 1'b1;
                match  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_dispatch.sv
// fsm_dispatch
// Top-level Control Unit sequencer: fetches an instruction, hands it to one
// instruction-class FSM, forwards that FSM's control word while it runs,
// counts retired instructions and traps on illegal codes or a stuck FSM.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   run          processor enable (level)
//   code         one-hot class code, stable during DECODE
//   done_i       per-FSM done pulses (only the selected one is honoured in RUN)
//   ctrl_i       per-FSM control words, FSM i at [i*CTRL_W +: CTRL_W]
//   trap_clr     acknowledges a trap
//   load_ir      instruction-register load strobe (FETCH)
//   start_o      one-hot start pulse to the selected FSM (START)
//   ctrl_o       forwarded control word (RUN only, else 0)
//   busy         high outside IDLE and TRAP
//   trap         high in TRAP
//   trap_cause   00 none, 01 illegal, 10 timeout
//   instret      retired-instruction counter (wraps)
// TIMEOUT must be in 2..255 and N_FSM must not exceed control_pkg::MAX_FSM.
module fsm_dispatch
    import control_pkg::*;
#(
    parameter int N_FSM   = 4,
    parameter int CTRL_W  = 24,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic [31:0]             code,
    input  logic [N_FSM-1:0]        done_i,
    input  logic [N_FSM*CTRL_W-1:0] ctrl_i,
    input  logic                    trap_clr,
    output logic                    load_ir,
    output logic [N_FSM-1:0]        start_o,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic                    busy,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [CNT_W-1:0]        instret
);

    // The watchdog holds the number of completed RUN cycles; reaching
    // TIMEOUT-1 during a RUN cycle means this is RUN cycle number TIMEOUT.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [N_FSM-1:0]   sel_q;
    logic [N_FSM-1:0]   sel_d;
    logic               match;
    logic [7:0]         wdog_q;
    logic [CNT_W-1:0]   instret_q;
    logic [1:0]         cause_q;
    logic               done_sel;
    logic               wdog_hit;
    logic [CTRL_W-1:0]  ctrl_mux;

    fsm_select #(
        .N_FSM (N_FSM)
    ) u_select (
        .code  (code),
        .sel   (sel_d),
        .match (match)
    );

    // Only the selected FSM's done counts; everything else is ignored.
    assign done_sel = |(done_i & sel_q);
    assign wdog_hit = (wdog_q == WDOG_LAST);

    // sel_q is one-hot (or zero), so OR-ing the gated slices is a mux.
    always_comb begin
        ctrl_mux = '0;
        for (int i = 0; i < N_FSM; i++) begin
            if (sel_q[i]) begin
                ctrl_mux = ctrl_mux | ctrl_i[i*CTRL_W +: CTRL_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; only ctrl_o looks at an input directly.
    always_comb begin
        state_d = state_q;
        load_ir = 1'b0;
        start_o = '0;
        ctrl_o  = '0;
        busy    = 1'b1;
        trap    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                load_ir = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = match ? START : TRAP;
            end
            START: begin
                start_o = sel_q;
                state_d = RUN;
            end
            RUN: begin
                ctrl_o = ctrl_mux;
                // done has priority over the watchdog in the same cycle
                if (done_sel) begin
                    state_d = run ? FETCH : IDLE;
                end else if (wdog_hit) begin
                    state_d = TRAP;
                end
            end
            TRAP: begin
                busy = 1'b0;
                trap = 1'b1;
                if (trap_clr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Selection latch, watchdog, retire counter and trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            wdog_q    <= '0;
            instret_q <= '0;
            cause_q   <= TRAP_NONE;
        end else begin
            case (state_q)
                DECODE: begin
                    if (match) begin
                        sel_q <= sel_d;
                    end else begin
                        sel_q   <= '0;
                        cause_q <= TRAP_ILLEGAL;
                    end
                end
                START: begin
                    wdog_q <= '0;
                end
                RUN: begin
                    if (done_sel) begin
                        instret_q <= instret_q + CNT_W'(1);
                    end else if (wdog_hit) begin
                        cause_q <= TRAP_TIMEOUT;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                TRAP: begin
                    if (trap_clr) begin
                        cause_q <= TRAP_NONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_fsm_dispatch.sv
// tb_fsm_dispatch
// Self-checking bench for fsm_dispatch. Expected start_o selections are
// pushed to a scoreboard queue when an instruction is issued and popped when
// the DUT pulses start_o; instret is tracked by a model counter that steps
// whenever the bench raises the selected FSM's done during RUN.
module tb_fsm_dispatch;

    localparam int N_FSM   = 4;
    localparam int CTRL_W  = 24;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    run;
    logic [31:0]             code;
    logic [N_FSM-1:0]        done_i;
    logic [N_FSM*CTRL_W-1:0] ctrl_i;
    logic                    trap_clr;
    logic                    load_ir;
    logic [N_FSM-1:0]        start_o;
    logic [CTRL_W-1:0]       ctrl_o;
    logic                    busy;
    logic                    trap;
    logic [1:0]              trap_cause;
    logic [CNT_W-1:0]        instret;

    typedef struct {
        logic [N_FSM-1:0] start;
    } exp_t;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] model_instret;
    int               checks = 0;
    int               passed = 0;

    fsm_dispatch #(
        .N_FSM   (N_FSM),
        .CTRL_W  (CTRL_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .code       (code),
        .done_i     (done_i),
        .ctrl_i     (ctrl_i),
        .trap_clr   (trap_clr),
        .load_ir    (load_ir),
        .start_o    (start_o),
        .ctrl_o     (ctrl_o),
        .busy       (busy),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the whole run.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ctrl();
        ctrl_i = {$urandom(), $urandom(), $urandom()};
    endtask

    function automatic logic [CTRL_W-1:0] slice(input int idx);
        return ctrl_i[idx*CTRL_W +: CTRL_W];
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        run      = 1'b0;
        code     = '0;
        done_i   = '0;
        trap_clr = 1'b0;
        randomize_ctrl();
        step();
        step();
        rst_n = 1'b1;
        model_instret = '0;
        exp_q.delete();
    endtask

    // Steps until start_o pulses, then pops and compares the expectation.
    task automatic wait_start(input string name);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (start_o !== '0) seen = 1'b1;
        end
        checks++;
        if (!seen || exp_q.size() == 0) begin
            $display("[TB] FAIL %s: start_o=%b seen=%0d queued=%0d", name, start_o, seen, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (start_o !== e.start)
                $display("[TB] FAIL %s: start_o got %b want %b", name, start_o, e.start);
            else
                passed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b1;
        code  = 32'h0000_1000;
        randomize_ctrl();
        #3;
        checks++;
        if ({load_ir, start_o, busy, trap, trap_cause} !== '0)
            $display("[TB] FAIL reset_outputs: got %b want 0", {load_ir, start_o, busy, trap, trap_cause});
        else passed++;
        checks++;
        if (ctrl_o !== '0) $display("[TB] FAIL reset_ctrl_o: got %h want 0", ctrl_o);
        else passed++;
        checks++;
        if (instret !== '0) $display("[TB] FAIL reset_instret: got %0d want 0", instret);
        else passed++;
        do_reset();
    endtask

    task automatic test_alu();
        do_reset();
        code = 32'h0000_1000;
        run  = 1'b1;
        exp_q.push_back('{start: 4'b0001});
        step();
        checks++;
        if (load_ir !== 1'b1) $display("[TB] FAIL alu_load_ir_c1: got %b want 1", load_ir);
        else passed++;
        step();
        checks++;
        if ({load_ir, start_o} !== 5'b0) $display("[TB] FAIL alu_decode_c2: got %b want 0", {load_ir, start_o});
        else passed++;
        step();
        begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (start_o !== e.start) $display("[TB] FAIL alu_start_c3: got %b want %b", start_o, e.start);
            else passed++;
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            randomize_ctrl();
            done_i = (k == 4) ? 4'b0001 : 4'b0000;
            #1;
            checks++;
            if (ctrl_o !== slice(0)) $display("[TB] FAIL alu_ctrl_run%0d: got %h want %h", k, ctrl_o, slice(0));
            else passed++;
        end
        model_instret = model_instret + 1;
        step();
        done_i = '0;
        checks++;
        if (instret !== model_instret) $display("[TB] FAIL alu_instret_c8: got %0d want %0d", instret, model_instret);
        else passed++;
        checks++;
        if (load_ir !== 1'b1) $display("[TB] FAIL alu_refetch_c8: got %b want 1", load_ir);
        else passed++;
    endtask

    task automatic test_illegal();
        logic [N_FSM-1:0] start_seen;
        do_reset();
        code = 32'h0000_0000;
        run  = 1'b1;
        start_seen = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            start_seen = start_seen | start_o;
        end
        checks++;
        if ({trap, trap_cause} !== 3'b101) $display("[TB] FAIL illegal_trap: got %b want 101", {trap, trap_cause});
        else passed++;
        for (int k = 0; k < 3; k++) begin
            step();
            start_seen = start_seen | start_o;
        end
        checks++;
        if ({trap, busy} !== 2'b10) $display("[TB] FAIL illegal_hold: trap/busy got %b want 10", {trap, busy});
        else passed++;
        checks++;
        if (start_seen !== '0) $display("[TB] FAIL illegal_no_start: got %b want 0", start_seen);
        else passed++;
        trap_clr = 1'b1;
        step();
        trap_clr = 1'b0;
        run      = 1'b0;
        checks++;
        if ({trap, busy, trap_cause} !== 4'b0000) $display("[TB] FAIL illegal_clear: got %b want 0000", {trap, busy, trap_cause});
        else passed++;
    endtask

    task automatic test_timeout();
        int runs;
        do_reset();
        code = 32'h0000_0010;
        run  = 1'b1;
        exp_q.push_back('{start: 4'b0010});
        wait_start("timeout_start");
        runs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (trap === 1'b1) break;
            runs++;
        end
        checks++;
        if (runs != TIMEOUT) $display("[TB] FAIL timeout_run_cycles: got %0d want %0d", runs, TIMEOUT);
        else passed++;
        checks++;
        if (trap_cause !== 2'b10) $display("[TB] FAIL timeout_cause: got %b want 10", trap_cause);
        else passed++;
        checks++;
        if (instret !== model_instret) $display("[TB] FAIL timeout_instret: got %0d want %0d", instret, model_instret);
        else passed++;
    endtask

    task automatic test_done_at_limit();
        do_reset();
        code = 32'h0001_0000;
        run  = 1'b1;
        exp_q.push_back('{start: 4'b1000});
        wait_start("limit_start");
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            randomize_ctrl();
            done_i = '0;
            if (k == 7) done_i = 4'b0010;
            if (k == TIMEOUT) done_i = 4'b1000;
            #1;
            if (k == 3) begin
                checks++;
                if (ctrl_o !== slice(3)) $display("[TB] FAIL limit_ctrl: got %h want %h", ctrl_o, slice(3));
                else passed++;
            end
            if (k == 8) begin
                checks++;
                if ({busy, load_ir} !== 2'b10) $display("[TB] FAIL spurious_done: busy/load_ir got %b want 10", {busy, load_ir});
                else passed++;
            end
        end
        model_instret = model_instret + 1;
        step();
        done_i = '0;
        checks++;
        if ({trap, load_ir} !== 2'b01) $display("[TB] FAIL limit_retire: trap/load_ir got %b want 01", {trap, load_ir});
        else passed++;
        checks++;
        if (instret !== model_instret) $display("[TB] FAIL limit_instret: got %0d want %0d", instret, model_instret);
        else passed++;
    endtask

    task automatic test_priority_run_drop();
        do_reset();
        code = 32'h0000_0110;
        run  = 1'b1;
        exp_q.push_back('{start: 4'b0010});
        wait_start("priority_start");
        step();
        run = 1'b0;
        randomize_ctrl();
        #1;
        checks++;
        if (ctrl_o !== slice(1)) $display("[TB] FAIL priority_ctrl: got %h want %h", ctrl_o, slice(1));
        else passed++;
        step();
        done_i = 4'b0110;
        model_instret = model_instret + 1;
        step();
        done_i = '0;
        checks++;
        if (instret !== model_instret) $display("[TB] FAIL rundrop_instret: got %0d want %0d", instret, model_instret);
        else passed++;
        step();
        checks++;
        if ({busy, load_ir} !== 2'b00) $display("[TB] FAIL rundrop_idle: busy/load_ir got %b want 00", {busy, load_ir});
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        code = 32'h0000_1000;
        run  = 1'b1;
        exp_q.push_back('{start: 4'b0001});
        exp_q.push_back('{start: 4'b0100});
        wait_start("b2b_start0");
        step();
        done_i = 4'b0001;
        model_instret = model_instret + 1;
        step();
        done_i = '0;
        code   = 32'h0000_0100;
        checks++;
        if (load_ir !== 1'b1) $display("[TB] FAIL b2b_refetch: got %b want 1", load_ir);
        else passed++;
        wait_start("b2b_start1");
        step();
        step();
        done_i = 4'b0100;
        run    = 1'b0;
        model_instret = model_instret + 1;
        step();
        done_i = '0;
        checks++;
        if (instret !== model_instret) $display("[TB] FAIL b2b_instret: got %0d want %0d", instret, model_instret);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        code = 32'h0000_1000;
        run  = 1'b1;
        exp_q.push_back('{start: 4'b0001});
        exp_q.push_back('{start: 4'b0001});
        wait_start("midrst_start0");
        step();
        done_i = 4'b0001;
        step();
        done_i = '0;
        wait_start("midrst_start1");
        step();
        randomize_ctrl();
        #2;
        rst_n = 1'b0;
        #1;
        model_instret = '0;
        checks++;
        if ({busy, load_ir, start_o, trap, trap_cause} !== '0)
            $display("[TB] FAIL midrst_outputs: got %b want 0", {busy, load_ir, start_o, trap, trap_cause});
        else passed++;
        checks++;
        if (ctrl_o !== '0) $display("[TB] FAIL midrst_ctrl_o: got %h want 0", ctrl_o);
        else passed++;
        checks++;
        if (instret !== model_instret) $display("[TB] FAIL midrst_instret: got %0d want %0d", instret, model_instret);
        else passed++;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (load_ir !== 1'b1) $display("[TB] FAIL midrst_fetch: got %b want 1", load_ir);
        else passed++;
        run = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        run      = 1'b0;
        code     = '0;
        done_i   = '0;
        ctrl_i   = '0;
        trap_clr = 1'b0;
        model_instret = '0;
        test_reset();
        test_alu();
        test_illegal();
        test_timeout();
        test_done_at_limit();
        test_priority_run_drop();
        test_back_to_back();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d want 0 entries", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
